icache_responder: RTL and testbench
===================================

Name: icache_responder

Overview:
- Direct-mapped instruction cache: the responder on the instruction half of the datapath–cache interface, answering the pipeline's imemREN/imemaddr requests with ihit/imemload.
- On a miss it becomes the initiator toward the memory controller (iREN/iaddr, waiting on iwait/iload) and fills one word-sized frame.
- Sits between the pipelined datapath and the memory arbiter; the pipeline advances its PC only on ihit.

Parameters:
- SETS, 16, number of frames; power of 2, range 2..256; IDX = log2(SETS).
- WORD_W, 32, width of data and address.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- imemREN  in  1  datapath instruction read request
- imemaddr  in  32  datapath fetch address (byte address, word aligned)
- ihit  out  1  requested word valid on imemload this cycle
- imemload  out  32  instruction word
- inv  in  1  synchronous invalidate-all strobe
- iREN  out  1  memory read request
- iaddr  out  32  memory read address
- iwait  in  1  memory busy; a low level while iREN is high means iload is valid
- iload  in  32  memory read data
- miss_count  out  32  number of completed fills, saturating

Behaviour:
- Address split: byte offset [1:0] is ignored; index is [IDX+1:2]; tag is [31:IDX+2].
- Storage per frame: valid bit, tag and data word.
  - Valid bits are reset by nRST.
  - Tag and data are not reset.
- Reset (nRST low, asynchronous): state=IDLE, all valid=0, iREN=0, iaddr=0, ihit=0, imemload=0, miss_count=0.
- State machine, two states: IDLE and FETCH.
- IDLE:
  - Hit = imemREN & valid[idx] & tag[idx]==tag(imemaddr).
  - On a hit, ihit=1 and imemload=data[idx]. Both are combinational, so the hit latency is 0 cycles.
  - On imemREN & ~hit: latch miss_addr = {imemaddr[31:2],2'b00} and go to FETCH at the next edge. ihit=0 throughout.
  - When imemREN=0, ihit=0 and no transition occurs.
- FETCH:
  - iREN=1 and iaddr=miss_addr, both registered, stable for every FETCH cycle. ihit=0.
  - The edge on which iwait=0: write data=iload, set tag, set valid=1 at the miss_addr index, increment miss_count (holds at 0xFFFFFFFF), return to IDLE.
  - The re-request hits on the following cycle. Minimum miss penalty is 2 cycles when iwait is already 0.
- Address change during FETCH (branch or jump redirect): the fetch is not aborted. The fill completes to the latched miss_addr, then IDLE re-evaluates the new imemaddr.
- imemREN dropping during FETCH: the fetch still completes and fills.
- imemload outside a hit: drives data[idx] of the current imemaddr. Consumers must qualify it with ihit.
- iREN is 0 in IDLE. iaddr holds its last value.
- inv (sampled on the edge):
  - In IDLE: all valid bits cleared. A hit combinationally present in that same cycle is still reported.
  - In FETCH: all valid bits cleared. If the fill completes on the same edge, the fill is written and its valid bit is set; a fill is always coherent with memory.
- Aliasing: two addresses with the same index and different tags evict each other. No replacement choice is made.
- Reset asserted mid-FETCH: iREN drops immediately (asynchronous), the fill is abandoned and the cache is empty.
- No write path: instruction memory is read-only through this block.

Test Plan:
1. Reset, then imemREN=1, imemaddr=0x00000000, with iwait low after 3 cycles and iload=0x8C010004 -> iREN=1 and iaddr=0 for 4 cycles; next cycle ihit=1, imemload=0x8C010004; miss_count=1.
2. Sequential fetch of 0x0, 0x4 … 0x3C (SETS=16) twice -> 16 misses on pass 1; pass 2 gives ihit=1 every cycle; miss_count=16.
3. Alias: fetch 0x00000040 after 0x00000000 is cached -> miss, fill at index 0; re-fetch 0x0 -> miss again; miss_count increments by 1 for each.
4. Redirect mid-FETCH: imemaddr changes 0x10 -> 0x80 while iwait=1 -> iaddr stays 0x10; after the fill, 0x10 is valid, then a miss starts on 0x80.
5. inv pulse while 0x0–0x3C are cached -> the next fetch of 0x8 misses. inv coincident with fill completion for 0x20 -> 0x20 subsequently hits.
6. nRST low while in FETCH (iREN=1) -> iREN=0 immediately; after release, the previously cached 0x0 misses; miss_count=0.

Source files
------------

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache answering datapath fetches (imemREN/imemaddr)
// with ihit/imemload, and filling one word per miss from the memory arbiter
// over iREN/iaddr/iwait/iload. dbg_state exposes the FSM (1 = FETCH).
//
// Handshake: the pipeline holds imemREN/imemaddr and advances only on ihit,
// which is combinational. Toward memory, iREN stays high for the whole fetch
// and the cycle in which iwait is low with iREN high carries valid iload data.
// That edge completes the fill.
module icache_responder #(
   parameter int SETS   = 16,
   parameter int WORD_W = 32
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              imemREN,
   input  logic [WORD_W-1:0] imemaddr,
   output logic              ihit,
   output logic [WORD_W-1:0] imemload,
   input  logic              inv,
   output logic              iREN,
   output logic [WORD_W-1:0] iaddr,
   input  logic              iwait,
   input  logic [WORD_W-1:0] iload,
   output logic [WORD_W-1:0] miss_count,
   output logic              dbg_state
);

   localparam int IDX   = $clog2(SETS);
   localparam int TAG_W = WORD_W - IDX - 2;

   typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [SETS-1:0]     valid_q, valid_d;
   logic                iren_q, iren_d;
   logic [WORD_W-1:0]   miss_addr_q, miss_addr_d;
   logic [WORD_W-1:0]   miss_count_q, miss_count_d;

   // Tag and data arrays carry no reset; valid_q alone decides emptiness.
   logic [TAG_W-1:0]    tag_q  [SETS];
   logic [WORD_W-1:0]   data_q [SETS];

   logic [IDX-1:0]      req_idx;
   logic [TAG_W-1:0]    req_tag;
   logic [IDX-1:0]      fill_idx;
   logic                lookup_hit;
   logic                fill_we;
   logic                unused_offset;

   assign req_idx       = imemaddr[IDX+1:2];
   assign req_tag       = imemaddr[WORD_W-1:IDX+2];
   assign fill_idx      = miss_addr_q[IDX+1:2];
   assign unused_offset = ^imemaddr[1:0];

   assign lookup_hit = imemREN && valid_q[req_idx] && (tag_q[req_idx] == req_tag);

   // Outside a hit imemload still shows the indexed frame; an empty frame reads 0.
   assign imemload   = valid_q[req_idx] ? data_q[req_idx] : '0;
   assign iREN       = iren_q;
   assign iaddr      = miss_addr_q;
   assign miss_count = miss_count_q;
   assign dbg_state  = state_q;

   // Next-state, fill strobe and valid-bit update for the IDLE/FETCH controller.
   always_comb begin
      state_d      = state_q;
      iren_d       = iren_q;
      miss_addr_d  = miss_addr_q;
      miss_count_d = miss_count_q;
      valid_d      = valid_q;
      fill_we      = 1'b0;
      ihit         = 1'b0;

      // Invalidate first so a fill landing on the same edge still sets its bit.
      if (inv) begin
         valid_d = '0;
      end

      case (state_q)
         IDLE: begin
            ihit = lookup_hit;
            if (imemREN && !lookup_hit) begin
               state_d     = FETCH;
               iren_d      = 1'b1;
               miss_addr_d = {imemaddr[WORD_W-1:2], 2'b00};
            end
         end
         FETCH: begin
            // Redirects and imemREN drops are ignored: the fill always finishes.
            if (!iwait) begin
               fill_we           = 1'b1;
               valid_d[fill_idx] = 1'b1;
               state_d           = IDLE;
               iren_d            = 1'b0;
               if (miss_count_q != '1) begin
                  miss_count_d = miss_count_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            iren_d  = 1'b0;
         end
      endcase
   end

   // Control registers; reset empties the cache and abandons any fill.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q      <= IDLE;
         valid_q      <= '0;
         iren_q       <= 1'b0;
         miss_addr_q  <= '0;
         miss_count_q <= '0;
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         iren_q       <= iren_d;
         miss_addr_q  <= miss_addr_d;
         miss_count_q <= miss_count_d;
      end
   end

   // Frame write on fill completion.
   always_ff @(posedge CLK) begin
      if (fill_we) begin
         tag_q[fill_idx]  <= miss_addr_q[WORD_W-1:IDX+2];
         data_q[fill_idx] <= iload;
      end
   end

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: inputs change 1 time unit after the
// rising edge, outputs are sampled on the falling edge.
module tb_icache_responder;

   logic        CLK;
   logic        nRST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        inv;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic [31:0] miss_count;
   logic        dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];

   icache_responder #(.SETS(16), .WORD_W(32)) dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .imemREN    (imemREN),
      .imemaddr   (imemaddr),
      .ihit       (ihit),
      .imemload   (imemload),
      .inv        (inv),
      .iREN       (iREN),
      .iaddr      (iaddr),
      .iwait      (iwait),
      .iload      (iload),
      .miss_count (miss_count),
      .dbg_state  (dbg_state)
   );

   // clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Backing-store contents used for every fill except test 1.
   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return 32'hC0DE_0000 | {16'h0000, addr[15:0]};
   endfunction

   // Present a missing address, hold iwait high for nwait FETCH cycles,
   // then return data; check the re-request hits. Ends at posedge+1.
   task automatic do_miss(input logic [31:0] addr, input logic [31:0] data,
                          input int nwait, output int ren_cycles);
      ren_cycles = 0;
      imemREN  = 1'b1;
      imemaddr = addr;
      iwait    = 1'b1;
      @(negedge CLK);
      check("miss_ihit", {31'd0, ihit}, 32'd0);
      tick();
      for (int i = 0; i < nwait; i++) begin
         @(negedge CLK);
         if (iREN) ren_cycles++;
         check("fetch_iaddr", iaddr, addr);
         tick();
      end
      iwait = 1'b0;
      iload = data;
      @(negedge CLK);
      if (iREN) ren_cycles++;
      check("fill_iaddr", iaddr, addr);
      tick();
      iwait = 1'b1;
      iload = 32'h0;
      @(negedge CLK);
      check("fill_ihit", {31'd0, ihit}, 32'd1);
      check("fill_load", imemload, data);
      tick();
   endtask

   task automatic expect_hit(input logic [31:0] addr, input logic [31:0] data);
      imemREN  = 1'b1;
      imemaddr = addr;
      @(negedge CLK);
      check("hit_ihit", {31'd0, ihit}, 32'd1);
      check("hit_load", imemload, data);
      tick();
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      tick();
      tick();
      nRST = 1'b1;
      tick();
   endtask

   int rc;

   initial begin
      nRST = 1'b0; imemREN = 1'b0; imemaddr = 32'h0; inv = 1'b0;
      iwait = 1'b1; iload = 32'h0;
      #3;
      check("rst_iren",  {31'd0, iREN}, 32'd0);
      check("rst_iaddr", iaddr, 32'd0);
      check("rst_ihit",  {31'd0, ihit}, 32'd0);
      check("rst_load",  imemload, 32'd0);
      check("rst_count", miss_count, 32'd0);
      check("rst_state", {31'd0, dbg_state}, 32'd0);
      tick();
      nRST = 1'b1;
      tick();

      // 1: single miss, 3 wait cycles -> iREN for 4 cycles
      do_miss(32'h0, 32'h8C01_0004, 3, rc);
      check("t1_ren_cycles", rc, 32'd4);
      check("t1_count", miss_count, 32'd1);
      imemREN = 1'b0;
      tick();
      check("t1_idle_iren", {31'd0, iREN}, 32'd0);
      check("t1_iaddr_hold", iaddr, 32'd0);

      // 2: sequential fill then all hits
      do_reset();
      for (int i = 0; i < 16; i++) begin
         do_miss(32'(i * 4), mem_word(32'(i * 4)), 0, rc);
         exp_q.push_back(mem_word(32'(i * 4)));
      end
      check("t2_count_p1", miss_count, 32'd16);
      for (int i = 0; i < 16; i++) begin
         expect_hit(32'(i * 4), exp_q.pop_front());
      end
      check("t2_count_p2", miss_count, 32'd16);

      // 3: alias eviction at index 0
      do_miss(32'h40, mem_word(32'h40), 1, rc);
      check("t3_count_a", miss_count, 32'd17);
      expect_hit(32'h4, mem_word(32'h4));
      do_miss(32'h0, mem_word(32'h0), 0, rc);
      check("t3_count_b", miss_count, 32'd18);

      // 4: redirect mid-fetch (0x50 first evicts 0x10)
      do_miss(32'h50, mem_word(32'h50), 0, rc);
      imemREN = 1'b1; imemaddr = 32'h10; iwait = 1'b1;
      @(negedge CLK);
      check("t4_miss", {31'd0, ihit}, 32'd0);
      tick();
      imemaddr = 32'h80;
      @(negedge CLK);
      check("t4_iaddr_a", iaddr, 32'h10);
      check("t4_ihit_f", {31'd0, ihit}, 32'd0);
      tick();
      @(negedge CLK);
      check("t4_iaddr_b", iaddr, 32'h10);
      tick();
      iwait = 1'b0; iload = mem_word(32'h10);
      tick();
      iwait = 1'b1;
      @(negedge CLK);
      check("t4_new_miss", {31'd0, ihit}, 32'd0);
      tick();
      @(negedge CLK);
      check("t4_iaddr_80", iaddr, 32'h80);
      check("t4_iren_80", {31'd0, iREN}, 32'd1);
      iwait = 1'b0; iload = mem_word(32'h80);
      tick();
      iwait = 1'b1;
      expect_hit(32'h80, mem_word(32'h80));
      expect_hit(32'h10, mem_word(32'h10));
      check("t4_count", miss_count, 32'd21);

      // 5: invalidate with coincident hit, then inv during fill completion
      imemREN = 1'b1; imemaddr = 32'h4; inv = 1'b1;
      @(negedge CLK);
      check("t5_inv_hit", {31'd0, ihit}, 32'd1);
      tick();
      inv = 1'b0;
      do_miss(32'h8, mem_word(32'h8), 0, rc);
      imemaddr = 32'h20; iwait = 1'b1;
      tick();
      iwait = 1'b0; iload = mem_word(32'h20); inv = 1'b1;
      tick();
      inv = 1'b0; iwait = 1'b1;
      expect_hit(32'h20, mem_word(32'h20));
      do_miss(32'h8, mem_word(32'h8), 0, rc);
      check("t5_count", miss_count, 32'd24);

      // 6: reset during FETCH
      do_miss(32'h0, mem_word(32'h0), 0, rc);
      imemREN = 1'b1; imemaddr = 32'h44; iwait = 1'b1;
      tick();
      @(negedge CLK);
      check("t6_iren_pre", {31'd0, iREN}, 32'd1);
      #2;
      nRST = 1'b0;
      #1;
      check("t6_iren_rst", {31'd0, iREN}, 32'd0);
      check("t6_count_rst", miss_count, 32'd0);
      tick();
      nRST = 1'b1;
      imemaddr = 32'h0;
      @(negedge CLK);
      check("t6_miss_0", {31'd0, ihit}, 32'd0);
      check("t6_count", miss_count, 32'd0);
      imemREN = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
